pacman_mover: RTL and testbench

- Requesting side of the collision query interface.
- Holds the Pacman position and heading.
- On each movement tick it asks the collision detector whether the requested direction is open. If that direction is blocked, it asks again for the current heading. It then advances, turns, or stops.
- Sits between the keyboard/direction decoder and the collision detector; p_x/p_y also feed the renderer.

---
 rtl/pacman_pkg.sv | 24 ++
 rtl/pos_stepper.sv | 55 +++++
 rtl/pacman_mover.sv | 126 ++++++++++++
 tb/tb_pacman_mover.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pacman_pkg.sv
// Shared types and helpers for the Pacman mover: one-hot directions, coordinate type, FSM states.
package pacman_pkg;

  localparam logic [3:0] DIR_L    = 4'b1000;
  localparam logic [3:0] DIR_U    = 4'b0100;
  localparam logic [3:0] DIR_R    = 4'b0010;
  localparam logic [3:0] DIR_D    = 4'b0001;
  localparam logic [3:0] DIR_NONE = 4'b0000;

  typedef logic [8:0] coord_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    Q_REQ = 3'd1,
    Q_CUR = 3'd2,
    MOVE  = 3'd3,
    HALT  = 3'd4
  } state_t;

  function automatic logic is_onehot4(input logic [3:0] d);
    return (d != 4'b0000) && ((d & (d - 4'd1)) == 4'b0000);
  endfunction

endpackage

// File: rtl/pos_stepper.sv
// Combinational next position for one step along a one-hot heading.
// PACMAN_TUNNEL_WRAP_EN selects horizontal tunnel wrap; otherwise x saturates at X_MIN/X_MAX.
module pos_stepper
  import pacman_pkg::*;
#(
  parameter int     STEP  = 1,
  parameter coord_t X_MIN = 9'd0,
  parameter coord_t X_MAX = 9'd223
) (
  input  coord_t     x,
  input  coord_t     y,
  input  logic [3:0] dir,
  output coord_t     nx,
  output coord_t     ny
);

  localparam coord_t STEP_C = coord_t'(STEP);

  always_comb begin
    nx = x;
    ny = y;
    case (dir)
      DIR_L: begin
        if (x < X_MIN + STEP_C) begin
`ifdef PACMAN_TUNNEL_WRAP_EN
          nx = X_MAX - (X_MIN + STEP_C - 9'd1 - x);
`else
          nx = X_MIN;
`endif
        end else begin
          nx = x - STEP_C;
        end
      end
      DIR_R: begin
        if (x > X_MAX - STEP_C) begin
`ifdef PACMAN_TUNNEL_WRAP_EN
          nx = X_MIN + (x + STEP_C - 9'd1 - X_MAX);
`else
          nx = X_MAX;
`endif
        end else begin
          nx = x + STEP_C;
        end
      end
      // Walls guarantee y never leaves the 9-bit range.
      DIR_U:   ny = y - STEP_C;
      DIR_D:   ny = y + STEP_C;
      default: begin
        nx = x;
        ny = y;
      end
    endcase
  end

endmodule

// File: rtl/pacman_mover.sv
// Pacman position/heading FSM: per tick, query requested direction, then current heading, then move or halt.
// Tunnel wrap is enabled by PACMAN_TUNNEL_WRAP_EN (handled in pos_stepper).
module pacman_mover
  import pacman_pkg::*;
#(
  parameter coord_t X_INIT    = 9'd104,
  parameter coord_t Y_INIT    = 9'd184,
  parameter int     STEP      = 1,
  parameter int     QUERY_LAT = 2,
  parameter coord_t X_MIN     = 9'd0,
  parameter coord_t X_MAX     = 9'd223
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       move_tick,
  input  logic [3:0] req_dir,
  input  logic       collide,
  output logic [3:0] query_dir,
  output coord_t     p_x,
  output coord_t     p_y,
  output logic [3:0] cur_dir,
  output logic       moving,
  output logic       busy
);

  localparam int CW = (QUERY_LAT < 1) ? 1 : $clog2(QUERY_LAT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(QUERY_LAT);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    heading;
  coord_t        nx;
  coord_t        ny;

  pos_stepper #(
    .STEP  (STEP),
    .X_MIN (X_MIN),
    .X_MAX (X_MAX)
  ) u_stepper (
    .x   (p_x),
    .y   (p_y),
    .dir (heading),
    .nx  (nx),
    .ny  (ny)
  );

  // heading doubles as the latched query direction, so query_dir stays frozen for the whole window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      heading   <= DIR_NONE;
      query_dir <= DIR_NONE;
      p_x       <= X_INIT;
      p_y       <= Y_INIT;
      cur_dir   <= DIR_NONE;
      moving    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (move_tick) begin
            cnt  <= '0;
            busy <= 1'b1;
            if (is_onehot4(req_dir)) begin
              state     <= Q_REQ;
              query_dir <= req_dir;
              heading   <= req_dir;
            end else begin
              state     <= Q_CUR;
              query_dir <= cur_dir;
              heading   <= cur_dir;
            end
          end
        end
        Q_REQ: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (!collide) begin
              state     <= MOVE;
              query_dir <= DIR_NONE;
            end else begin
              state     <= Q_CUR;
              query_dir <= cur_dir;
              heading   <= cur_dir;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        Q_CUR: begin
          if (cur_dir == DIR_NONE) begin
            state     <= HALT;
            query_dir <= DIR_NONE;
          end else if (cnt == CNT_LAST) begin
            cnt       <= '0;
            query_dir <= DIR_NONE;
            state     <= collide ? HALT : MOVE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        MOVE: begin
          p_x     <= nx;
          p_y     <= ny;
          cur_dir <= heading;
          // A clamped move at the edge leaves x unchanged and does not count as moving.
          moving  <= (nx != p_x) || (ny != p_y);
          state   <= IDLE;
          busy    <= 1'b0;
        end
        HALT: begin
          moving  <= 1'b0;
          cur_dir <= DIR_NONE;
          state   <= IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pacman_mover.sv
// Directed bench for pacman_mover; collide is modelled as "queried direction is in the blocked mask".
module tb_pacman_mover;

  logic       clk;
  logic       rst_n;
  logic       move_tick;
  logic [3:0] req_dir;
  logic       collide;
  logic [3:0] query_dir;
  logic [8:0] p_x;
  logic [8:0] p_y;
  logic [3:0] cur_dir;
  logic       moving;
  logic       busy;

  logic [3:0] blocked;
  logic [3:0] qlog [0:39];
  int         checks;
  int         errors;

  localparam logic [3:0] L = 4'b1000;
  localparam logic [3:0] U = 4'b0100;
  localparam logic [3:0] R = 4'b0010;
  localparam logic [3:0] D = 4'b0001;

  assign collide = |(query_dir & blocked);

  pacman_mover dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .move_tick (move_tick),
    .req_dir   (req_dir),
    .collide   (collide),
    .query_dir (query_dir),
    .p_x       (p_x),
    .p_y       (p_y),
    .cur_dir   (cur_dir),
    .moving    (moving),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulses move_tick for one cycle, then logs query_dir each busy cycle until IDLE.
  task automatic do_tick(input logic [3:0] d, output int n);
    @(negedge clk);
    move_tick = 1'b1;
    req_dir   = d;
    @(negedge clk);
    move_tick = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      qlog[n] = query_dir;
      n++;
      @(negedge clk);
    end
    checks++;
    if (n >= 40) begin
      errors++;
      $display("FAIL tick_timeout: busy cycles %0d, required < 40", n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; move_tick = 1'b0; req_dir = 4'b0000; blocked = 4'b0000;
    repeat (3) @(negedge clk);
    checks++;
    if (p_x !== 9'd104 || p_y !== 9'd184) begin
      errors++; $display("FAIL reset_pos: got %0d,%0d required 104,184", p_x, p_y);
    end
    checks++;
    if (cur_dir !== 4'b0000 || query_dir !== 4'b0000 || moving !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl: cur_dir %b query_dir %b moving %b busy %b required 0000 0000 0 0",
               cur_dir, query_dir, moving, busy);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_move_right();
    int n;
    blocked = 4'b0000;
    do_tick(R, n);
    checks++;
    if (n !== 4) begin errors++; $display("FAIL right_busy_cycles: got %0d required 4", n); end
    checks++;
    if (qlog[0] !== R || qlog[1] !== R || qlog[2] !== R) begin
      errors++; $display("FAIL right_query: got %b %b %b required 0010 x3", qlog[0], qlog[1], qlog[2]);
    end
    checks++;
    if (p_x !== 9'd105 || p_y !== 9'd184 || cur_dir !== R || moving !== 1'b1) begin
      errors++;
      $display("FAIL right_result: x %0d y %0d dir %b moving %b required 105 184 0010 1", p_x, p_y, cur_dir, moving);
    end
  endtask

  task automatic test_turn_blocked();
    int n;
    blocked = 4'b0000;
    do_tick(L, n);
    checks++;
    if (p_x !== 9'd104 || cur_dir !== L) begin
      errors++; $display("FAIL turn_setup: x %0d dir %b required 104 1000", p_x, cur_dir);
    end
    blocked = U;
    do_tick(U, n);
    checks++;
    if (n !== 7) begin errors++; $display("FAIL turn_busy_cycles: got %0d required 7", n); end
    checks++;
    if (qlog[0] !== U || qlog[2] !== U || qlog[3] !== L || qlog[5] !== L) begin
      errors++;
      $display("FAIL turn_query_seq: got %b %b %b %b required 0100 0100 1000 1000", qlog[0], qlog[2], qlog[3], qlog[5]);
    end
    checks++;
    if (p_x !== 9'd103 || p_y !== 9'd184 || cur_dir !== L || moving !== 1'b1) begin
      errors++;
      $display("FAIL turn_result: x %0d y %0d dir %b moving %b required 103 184 1000 1", p_x, p_y, cur_dir, moving);
    end
  endtask

  task automatic test_halt();
    int n;
    blocked = L | U;
    do_tick(U, n);
    checks++;
    if (p_x !== 9'd103 || p_y !== 9'd184 || cur_dir !== 4'b0000 || moving !== 1'b0) begin
      errors++;
      $display("FAIL halt_result: x %0d y %0d dir %b moving %b required 103 184 0000 0", p_x, p_y, cur_dir, moving);
    end
    do_tick(4'b0000, n);
    checks++;
    if (n !== 2 || qlog[0] !== 4'b0000) begin
      errors++; $display("FAIL halt_no_req: busy %0d query %b required 2 0000", n, qlog[0]);
    end
    do_tick(4'b1010, n);
    checks++;
    if (n !== 2 || qlog[0] !== 4'b0000 || p_x !== 9'd103 || cur_dir !== 4'b0000) begin
      errors++;
      $display("FAIL halt_multibit: busy %0d query %b x %0d dir %b required 2 0000 103 0000", n, qlog[0], p_x, cur_dir);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [3:0] seen [0:2];
    blocked = 4'b0000;
    @(negedge clk);
    move_tick = 1'b1; req_dir = R;
    @(negedge clk);
    seen[0] = query_dir;
    req_dir = U;
    @(negedge clk);
    seen[1] = query_dir;
    move_tick = 1'b0; req_dir = D;
    @(negedge clk);
    seen[2] = query_dir;
    n = 0;
    while (busy === 1'b1 && n < 40) begin n++; @(negedge clk); end
    repeat (6) @(negedge clk);
    checks++;
    if (seen[0] !== R || seen[1] !== R || seen[2] !== R) begin
      errors++; $display("FAIL b2b_query_hold: got %b %b %b required 0010 x3", seen[0], seen[1], seen[2]);
    end
    checks++;
    if (p_x !== 9'd104 || p_y !== 9'd184 || cur_dir !== R || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_single_move: x %0d y %0d dir %b busy %b required 104 184 0010 0", p_x, p_y, cur_dir, busy);
    end
  endtask

  task automatic test_boundary();
    int n;
    blocked = 4'b0000;
    for (int i = 0; i < 104; i++) do_tick(L, n);
    checks++;
    if (p_x !== 9'd0 || cur_dir !== L) begin
      errors++; $display("FAIL edge_reach: x %0d dir %b required 0 1000", p_x, cur_dir);
    end
    do_tick(L, n);
    checks++;
`ifdef PACMAN_TUNNEL_WRAP_EN
    if (p_x !== 9'd223 || moving !== 1'b1) begin
      errors++; $display("FAIL edge_left: x %0d moving %b required 223 1", p_x, moving);
    end
`else
    if (p_x !== 9'd0 || moving !== 1'b0) begin
      errors++; $display("FAIL edge_left: x %0d moving %b required 0 0", p_x, moving);
    end
`endif
    do_tick(R, n);
    checks++;
`ifdef PACMAN_TUNNEL_WRAP_EN
    if (p_x !== 9'd0 || moving !== 1'b1) begin
      errors++; $display("FAIL edge_right: x %0d moving %b required 0 1", p_x, moving);
    end
`else
    if (p_x !== 9'd1 || moving !== 1'b1) begin
      errors++; $display("FAIL edge_right: x %0d moving %b required 1 1", p_x, moving);
    end
`endif
  endtask

  task automatic test_reset_mid();
    blocked = 4'b0000;
    @(negedge clk);
    move_tick = 1'b1; req_dir = R;
    @(negedge clk);
    move_tick = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (p_x !== 9'd104 || p_y !== 9'd184 || cur_dir !== 4'b0000 || moving !== 1'b0 ||
        busy !== 1'b0 || query_dir !== 4'b0000) begin
      errors++;
      $display("FAIL reset_mid: x %0d y %0d dir %b moving %b busy %b q %b required 104 184 0000 0 0 0000",
               p_x, p_y, cur_dir, moving, busy, query_dir);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || p_x !== 9'd104) begin
      errors++; $display("FAIL reset_mid_after: busy %b x %0d required 0 104", busy, p_x);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_move_right();
    test_turn_blocked();
    test_halt();
    test_back_to_back();
    test_boundary();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
